riscv_i32_dmem_response: RTL

RISCV_I32_DMEM_RESPONSE -- requirements
Module: riscv_i32_dmem_response

---
 rtl/riscv_i32_dmem_response.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/riscv_i32_dmem_response.sv
// Load response path for an RV32I data port: rotates, merges, masks and sign-extends
// memory read words into the final load result, including two-beat misaligned loads.
module riscv_i32_dmem_response (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_reading,
  input  logic [31:0] req_address,
  input  logic [1:0]  req_rotation,
  input  logic [3:0]  req_byte_enable,
  input  logic        req_sign_extend_byte,
  input  logic        req_sign_extend_half,
  input  logic        req_multicycle,
  input  logic        flush,
  input  logic        mem_resp_valid,
  input  logic        mem_resp_error,
  input  logic [31:0] mem_resp_data,
  input  logic        second_req_ack,
  output logic        busy,
  output logic        second_req_valid,
  output logic [31:0] second_req_address,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        load_error
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_FIRST  = 2'd1,
    REQ_SECOND  = 2'd2,
    WAIT_SECOND = 2'd3
  } state_t;

  // Everything needed to shape the result, captured once when the load is accepted.
  typedef struct packed {
    logic [1:0] rotation;
    logic [3:0] byte_enable;
    logic       sext_byte;
    logic       sext_half;
    logic       multicycle;
  } load_ctrl_t;

  state_t     state_q;
  load_ctrl_t ctrl_q;
  logic [31:0] merge_q;
  logic [31:0] second_addr_q;
  logic        load_valid_q;
  logic [31:0] load_data_q;
  logic        load_error_q;

  // Result byte i takes memory byte (i + rot) mod 4.
  function automatic logic [31:0] rotate_right(input logic [31:0] d, input logic [1:0] rot);
    case (rot)
      2'd0:    return d;
      2'd1:    return {d[7:0],  d[31:8]};
      2'd2:    return {d[15:0], d[31:16]};
      default: return {d[23:0], d[31:24]};
    endcase
  endfunction

  function automatic logic [31:0] mask_extend(input logic [31:0] d,
                                              input logic [3:0]  be,
                                              input logic        sb,
                                              input logic        sh);
    logic [31:0] r;
    r = d & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if (sb) begin
      r[31:8] = {24{r[7]}};
    end else if (sh) begin
      r[31:16] = {16{r[15]}};
    end
    return r;
  endfunction

  // Low bytes come from the first word, the tail of the access from the second.
  function automatic logic [31:0] merge_words(input logic [31:0] first_rot,
                                              input logic [31:0] second_rot,
                                              input logic [1:0]  rot);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (i + int'(rot) < 4) begin
        r[8*i +: 8] = first_rot[8*i +: 8];
      end else begin
        r[8*i +: 8] = second_rot[8*i +: 8];
      end
    end
    return r;
  endfunction

  logic [31:0] resp_rot;
  logic [31:0] single_result;
  logic [31:0] merged_result;
  logic [31:0] next_word_addr;
  logic        accept_req;

  assign resp_rot       = rotate_right(mem_resp_data, ctrl_q.rotation);
  assign single_result  = mask_extend(resp_rot, ctrl_q.byte_enable,
                                      ctrl_q.sext_byte, ctrl_q.sext_half);
  assign merged_result  = mask_extend(merge_words(merge_q, resp_rot, ctrl_q.rotation),
                                      ctrl_q.byte_enable, ctrl_q.sext_byte, ctrl_q.sext_half);
  assign next_word_addr = (req_address & ~32'd3) + 32'd4;
  assign accept_req     = req_valid && req_reading;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ctrl_q        <= '0;
      merge_q       <= '0;
      second_addr_q <= '0;
      load_valid_q  <= 1'b0;
      load_data_q   <= '0;
      load_error_q  <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      if (flush) begin
        // A response arriving with flush belongs to the cancelled load and is dropped.
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept_req) begin
              ctrl_q.rotation    <= req_rotation;
              ctrl_q.byte_enable <= req_byte_enable;
              ctrl_q.sext_byte   <= req_sign_extend_byte;
              ctrl_q.sext_half   <= req_sign_extend_half;
              ctrl_q.multicycle  <= req_multicycle;
              second_addr_q      <= next_word_addr;
              state_q            <= WAIT_FIRST;
            end
          end

          WAIT_FIRST: begin
            if (mem_resp_valid) begin
              if (mem_resp_error) begin
                load_valid_q <= 1'b1;
                load_error_q <= 1'b1;
                load_data_q  <= '0;
                state_q      <= IDLE;
              end else if (ctrl_q.multicycle) begin
                merge_q <= resp_rot;
                state_q <= REQ_SECOND;
              end else begin
                load_valid_q <= 1'b1;
                load_error_q <= 1'b0;
                load_data_q  <= single_result;
                state_q      <= IDLE;
              end
            end
          end

          REQ_SECOND: begin
            if (second_req_ack) begin
              state_q <= WAIT_SECOND;
            end
          end

          WAIT_SECOND: begin
            if (mem_resp_valid) begin
              load_valid_q <= 1'b1;
              load_error_q <= mem_resp_error;
              load_data_q  <= mem_resp_error ? 32'd0 : merged_result;
              state_q      <= IDLE;
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy               = (state_q != IDLE);
  assign second_req_valid   = (state_q == REQ_SECOND);
  assign second_req_address = second_addr_q;
  assign load_valid         = load_valid_q;
  assign load_data          = load_data_q;
  assign load_error         = load_error_q;

endmodule
